alu_sequencer: RTL

//  Registered command front-end for the combinational 4-bit alu: accepts {opcode, A, B} commands over valid/ready,

---
 rtl/alu_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: registered valid/ready command front-end for the combinational alu.
//   Accepts {opcode, A, B} commands, drives the alu inputs from registers, holds them for
//   SETTLE_CYCLES, captures result + flags, and returns one response per command.
//   Optional feature macro: ALU_SEQ_STICKY_FLAGS_EN (adds sticky_flags / sticky_clr).
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_opcode, cmd_a, cmd_b          command fields
//   cmd_chain                         1: use accumulator (last good result) as operand A
//   alu_a, alu_b, alu_opcode          registered drive to the alu
//   alu_result, alu_flags             alu outputs {carry, zero, negative, overflow}
//   rsp_valid/rsp_ready               response handshake
//   rsp_result, rsp_flags, rsp_err    captured response; err on DIV by zero or opcode 1110
//   sticky_flags, sticky_clr          (ALU_SEQ_STICKY_FLAGS_EN only) OR of all captured flags
module alu_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    output logic [3:0]       sticky_flags,
    input  logic             sticky_clr
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state, next_state;
    logic [3:0]       cnt;
    logic             err;
    logic [WIDTH-1:0] acc;
    logic             accept, capture, done;
    logic [WIDTH-1:0] cap_result;
    logic [3:0]       cap_flags;

    // Ready is gated by rst_n so it reads 0 while reset is asserted.
    assign cmd_ready  = rst_n && (state == IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign capture    = (state == ISSUE) && (cnt == 4'd1);
    assign done       = (state == RESP) && rsp_ready;
    assign cap_result = err ? '0 : alu_result;
    assign cap_flags  = err ? 4'b0100 : alu_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept  ? ISSUE : IDLE;
            ISSUE:   next_state = capture ? RESP  : ISSUE;
            RESP:    next_state = done    ? IDLE  : RESP;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            acc        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                alu_opcode <= cmd_opcode;
                alu_b      <= cmd_b;
                alu_a      <= cmd_chain ? acc : cmd_a;
                cnt        <= 4'(SETTLE_CYCLES);
                // Error is decided once from the accepted command, not from the alu.
                err        <= (cmd_opcode == 4'b0110 && cmd_b == '0) || cmd_opcode == 4'b1110;
            end else if (state == ISSUE) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= cap_result;
                rsp_flags  <= cap_flags;
                rsp_err    <= err;
                if (!err) acc <= alu_result;
            end else if (done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          sticky_flags <= '0;
        else if (sticky_clr) sticky_flags <= '0;
        else if (capture)    sticky_flags <= sticky_flags | cap_flags;
    end
`endif

endmodule
